// File: rtl/alu_issue_stage.sv
// ID/EX stage in front of the ALU: holds one decoded instruction, forwards operands
// from EX/MEM and MEM/WB, stalls on load-use hazards and supports flush.
module alu_issue_stage #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_operation,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rs2,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rd,
    input  logic [WORD_BITWIDTH-1:0]    in_rs1_data,
    input  logic [WORD_BITWIDTH-1:0]    in_rs2_data,
    input  logic [WORD_BITWIDTH-1:0]    in_imm,
    input  logic                        in_use_imm,
    input  logic                        in_reg_write,
    input  logic                        exmem_reg_write,
    input  logic                        exmem_is_load,
    input  logic [REG_NUM_BITWIDTH-1:0] exmem_rd,
    input  logic [WORD_BITWIDTH-1:0]    exmem_data,
    input  logic                        memwb_reg_write,
    input  logic [REG_NUM_BITWIDTH-1:0] memwb_rd,
    input  logic [WORD_BITWIDTH-1:0]    memwb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [3:0]                  operation,
    output logic [WORD_BITWIDTH-1:0]    addend1,
    output logic [WORD_BITWIDTH-1:0]    addend2,
    output logic [REG_NUM_BITWIDTH-1:0] out_rd,
    output logic                        out_reg_write
);
    // Handshake: a transfer occurs on a rising edge where valid && ready are both 1.
    // in_ready never depends on in_valid; out_valid never depends on out_ready.

    logic                        r_held_valid;
    logic [3:0]                  r_op;
    logic [REG_NUM_BITWIDTH-1:0] r_rs1;
    logic [REG_NUM_BITWIDTH-1:0] r_rs2;
    logic [REG_NUM_BITWIDTH-1:0] r_rd;
    logic [WORD_BITWIDTH-1:0]    r_rs1_data;
    logic [WORD_BITWIDTH-1:0]    r_rs2_data;
    logic [WORD_BITWIDTH-1:0]    r_imm;
    logic                        r_use_imm;
    logic                        r_reg_write;

    logic                        w_ex_hit1;
    logic                        w_ex_hit2;
    logic                        w_wb_hit1;
    logic                        w_wb_hit2;
    logic [WORD_BITWIDTH-1:0]    w_src1;
    logic [WORD_BITWIDTH-1:0]    w_src2;
    logic                        w_hazard;
    logic                        w_out_valid;
    logic                        w_fire;
    logic                        w_capture;

    // A load in EX/MEM has no data yet, so it never forwards; register 0 is never forwarded.
    assign w_ex_hit1 = exmem_reg_write && !exmem_is_load && (r_rs1 != '0) && (exmem_rd == r_rs1);
    assign w_ex_hit2 = exmem_reg_write && !exmem_is_load && (r_rs2 != '0) && (exmem_rd == r_rs2);
    assign w_wb_hit1 = memwb_reg_write && (r_rs1 != '0) && (memwb_rd == r_rs1);
    assign w_wb_hit2 = memwb_reg_write && (r_rs2 != '0) && (memwb_rd == r_rs2);

    assign w_src1 = w_ex_hit1 ? exmem_data :
                    w_wb_hit1 ? memwb_data : r_rs1_data;
    assign w_src2 = r_use_imm ? r_imm      :
                    w_ex_hit2 ? exmem_data :
                    w_wb_hit2 ? memwb_data : r_rs2_data;

    assign w_hazard = r_held_valid && exmem_reg_write && exmem_is_load && (exmem_rd != '0) &&
                      ((exmem_rd == r_rs1) || (!r_use_imm && (exmem_rd == r_rs2)));

    assign w_out_valid = r_held_valid && !w_hazard;
    assign w_fire      = w_out_valid && out_ready;
    assign in_ready    = !r_held_valid || w_fire;
    assign w_capture   = in_valid && in_ready;

    // Bubbles drive zeros so the ALU zero flag reads 1 when nothing is issued.
    assign out_valid     = w_out_valid;
    assign operation     = w_out_valid ? r_op   : 4'b0000;
    assign addend1       = w_out_valid ? w_src1 : '0;
    assign addend2       = w_out_valid ? w_src2 : '0;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write && w_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_held_valid <= 1'b0;
            r_op         <= 4'b0000;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_use_imm    <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (flush) begin
            r_held_valid <= 1'b0;
        end else if (w_capture) begin
            r_held_valid <= 1'b1;
            r_op         <= in_operation;
            r_rs1        <= in_rs1;
            r_rs2        <= in_rs2;
            r_rd         <= in_rd;
            r_rs1_data   <= in_rs1_data;
            r_rs2_data   <= in_rs2_data;
            r_imm        <= in_imm;
            r_use_imm    <= in_use_imm;
            r_reg_write  <= in_reg_write;
        end else if (w_fire) begin
            r_held_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by randomized
// traffic compared against a queue-based reference model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [3:0]  in_operation;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm, in_reg_write;
    logic        exmem_reg_write, exmem_is_load;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        out_valid, out_ready;
    logic [3:0]  operation;
    logic [31:0] addend1, addend2;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        ui;
        logic        rw;
    } instr_t;

    instr_t exp_q[$];

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_operation(in_operation),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
        .addend1(addend1), .addend2(addend2), .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    // ---------------- clock / reset helpers ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_operation = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_use_imm = 0; in_reg_write = 0;
        exmem_reg_write = 0; exmem_is_load = 0; exmem_rd = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
        out_ready = 0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic ui);
        in_valid = 1; in_operation = op;
        in_rs1 = rs1; in_rs1_data = d1;
        in_rs2 = rs2; in_rs2_data = d2;
        in_rd = rd; in_imm = imm; in_use_imm = ui; in_reg_write = 1;
    endtask

    task automatic clear_pipe();
        exmem_reg_write = 0; exmem_is_load = 0; exmem_rd = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (exmem_reg_write && !exmem_is_load && exmem_rd == src) return exmem_data;
        if (memwb_reg_write && memwb_rd == src) return memwb_data;
        return rf;
    endfunction

    task automatic model_check_cycle(input int c);
        instr_t      h;
        logic        held, stall, ev, er;
        logic [31:0] e1, e2;
        held  = (exp_q.size() != 0);
        h     = held ? exp_q[0] : '0;
        stall = held && exmem_reg_write && exmem_is_load && exmem_rd != 0 &&
                (exmem_rd == h.rs1 || (!h.ui && exmem_rd == h.rs2));
        ev    = held && !stall;
        er    = !held || (ev && out_ready);
        e1    = ev ? ref_fwd(h.rs1, h.d1) : 32'h0;
        e2    = !ev ? 32'h0 : (h.ui ? h.imm : ref_fwd(h.rs2, h.d2));
        check($sformatf("rnd%0d.out_valid", c), {31'b0, out_valid}, {31'b0, ev});
        check($sformatf("rnd%0d.in_ready", c), {31'b0, in_ready}, {31'b0, er});
        check($sformatf("rnd%0d.operation", c), {28'b0, operation}, {28'b0, (ev ? h.op : 4'b0)});
        check($sformatf("rnd%0d.addend1", c), addend1, e1);
        check($sformatf("rnd%0d.addend2", c), addend2, e2);
        check($sformatf("rnd%0d.out_reg_write", c), {31'b0, out_reg_write}, {31'b0, ev && h.rw});
        if (ev) check($sformatf("rnd%0d.out_rd", c), {27'b0, out_rd}, {27'b0, h.rd});
    endtask

    task automatic model_update_at_edge();
        logic held, stall, fire, acc;
        held  = (exp_q.size() != 0);
        stall = held && exmem_reg_write && exmem_is_load && exmem_rd != 0 &&
                (exmem_rd == exp_q[0].rs1 || (!exp_q[0].ui && exmem_rd == exp_q[0].rs2));
        fire  = held && !stall && out_ready;
        acc   = in_valid && (!held || fire);
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (acc) exp_q.push_back('{op: in_operation, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                                       d1: in_rs1_data, d2: in_rs2_data, imm: in_imm,
                                       ui: in_use_imm, rw: in_reg_write});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        settle();
        check("reset.out_valid", {31'b0, out_valid}, 32'd0);
        check("reset.operation", {28'b0, operation}, 32'd0);
        check("reset.addend1", addend1, 32'd0);
        check("reset.addend2", addend2, 32'd0);
        check("reset.in_ready", {31'b0, in_ready}, 32'd1);
        check("reset.out_rd", {27'b0, out_rd}, 32'd0);
        check("reset.out_reg_write", {31'b0, out_reg_write}, 32'd0);
        reset = 0;

        // back-to-back ADD then SUB, no bubble
        out_ready = 1;
        offer(4'd2, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 1'b0);
        tick();
        offer(4'd6, 5'd8, 32'd9, 5'd9, 32'd4, 5'd10, 32'd0, 1'b0);
        settle();
        check("b2b.add.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.add.op", {28'b0, operation}, 32'd2);
        check("b2b.add.addend1", addend1, 32'd5);
        check("b2b.add.addend2", addend2, 32'd7);
        check("b2b.add.rd", {27'b0, out_rd}, 32'd3);
        check("b2b.add.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
        settle();
        check("b2b.sub.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.sub.op", {28'b0, operation}, 32'd6);
        check("b2b.sub.addend1", addend1, 32'd9);
        check("b2b.sub.addend2", addend2, 32'd4);
        tick();
        check("b2b.drain.valid", {31'b0, out_valid}, 32'd0);
        check("b2b.drain.addend1", addend1, 32'd0);

        // forwarding priority
        out_ready = 0;
        offer(4'd2, 5'd3, 32'h11, 5'd5, 32'h22, 5'd6, 32'd0, 1'b0);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_data = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'hBB;
        settle();
        check("fwd.exmem_wins", addend1, 32'hAA);
        exmem_reg_write = 0;
        settle();
        check("fwd.memwb", addend1, 32'hBB);
        memwb_reg_write = 0;
        settle();
        check("fwd.none", addend1, 32'h11);
        out_ready = 1;
        tick();
        out_ready = 0;
        offer(4'd2, 5'd0, 32'h33, 5'd5, 32'h22, 5'd6, 32'd0, 1'b0);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 0; exmem_data = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hBB;
        settle();
        check("fwd.r0_not_forwarded", addend1, 32'h33);
        clear_pipe();
        out_ready = 1;
        tick();

        // load-use hazard on rs2
        offer(4'd2, 5'd6, 32'd1, 5'd4, 32'h99, 5'd7, 32'd0, 1'b0);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_is_load = 1; exmem_rd = 4;
        settle();
        check("lu.stall.valid", {31'b0, out_valid}, 32'd0);
        check("lu.stall.in_ready", {31'b0, in_ready}, 32'd0);
        check("lu.stall.addend2", addend2, 32'd0);
        tick();
        clear_pipe();
        memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'h1234;
        settle();
        check("lu.resolve.valid", {31'b0, out_valid}, 32'd1);
        check("lu.resolve.addend2", addend2, 32'h1234);
        check("lu.resolve.addend1", addend1, 32'd1);
        tick();
        clear_pipe();
        offer(4'd2, 5'd6, 32'd1, 5'd4, 32'h99, 5'd7, 32'h55, 1'b1);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_is_load = 1; exmem_rd = 4;
        settle();
        check("lu.imm.valid", {31'b0, out_valid}, 32'd1);
        check("lu.imm.addend2", addend2, 32'h55);
        tick();
        clear_pipe();

        // backpressure
        out_ready = 0;
        offer(4'd3, 5'd10, 32'hA0, 5'd11, 32'hB0, 5'd12, 32'd0, 1'b0);
        tick();
        offer(4'd4, 5'd13, 32'hC0, 5'd14, 32'hD0, 5'd15, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("bp%0d.valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp%0d.addend1", k), addend1, 32'hA0);
            check($sformatf("bp%0d.addend2", k), addend2, 32'hB0);
            check($sformatf("bp%0d.in_ready", k), {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1;
        settle();
        check("bp.release.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
        settle();
        check("bp.next.valid", {31'b0, out_valid}, 32'd1);
        check("bp.next.addend1", addend1, 32'hC0);
        check("bp.next.op", {28'b0, operation}, 32'd4);
        tick();
        check("bp.drain.valid", {31'b0, out_valid}, 32'd0);

        // flush drops held and offered instruction
        out_ready = 0;
        offer(4'd5, 5'd1, 32'h77, 5'd2, 32'h78, 5'd7, 32'd0, 1'b0);
        tick();
        offer(4'd7, 5'd1, 32'hDD, 5'd2, 32'hDE, 5'd9, 32'd0, 1'b0);
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        settle();
        check("flush.valid", {31'b0, out_valid}, 32'd0);
        check("flush.in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("flush.after%0d.valid", k), {31'b0, out_valid}, 32'd0);
        end

        // reset while stalled
        offer(4'd2, 5'd5, 32'h10, 5'd6, 32'h20, 5'd8, 32'd0, 1'b0);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_is_load = 1; exmem_rd = 5;
        settle();
        check("rst_stall.pre.valid", {31'b0, out_valid}, 32'd0);
        reset = 1;
        tick();
        reset = 0;
        clear_pipe();
        settle();
        check("rst_stall.valid", {31'b0, out_valid}, 32'd0);
        check("rst_stall.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_stall.addend1", addend1, 32'd0);

        // randomized traffic against the reference model (DUT is empty here)
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 63) == 0);
            flush           = ($urandom_range(0, 15) == 0);
            in_valid        = ($urandom_range(0, 9) < 7);
            out_ready       = ($urandom_range(0, 9) < 7);
            in_operation    = 4'($urandom_range(0, 15));
            in_rs1          = 5'($urandom_range(0, 3));
            in_rs2          = 5'($urandom_range(0, 3));
            in_rd           = 5'($urandom_range(0, 31));
            in_rs1_data     = $urandom;
            in_rs2_data     = $urandom;
            in_imm          = $urandom;
            in_use_imm      = ($urandom_range(0, 3) == 0);
            in_reg_write    = 1'($urandom_range(0, 1));
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_is_load   = ($urandom_range(0, 2) == 0);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_data      = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_data      = $urandom;
            settle();
            model_check_cycle(c);
            @(posedge clk);
            model_update_at_edge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
